stopwatch_ctrl: RTL

Timekeeping core of the stopwatch. It sits between the clock-enable generator and debouncers upstream and the seven-segment display driver downstream. It counts MM:SS on a 1 Hz enable and supports pause/resume and per-field adjustment on a 2 Hz enable. It also drives per-field blink enables for the display.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/stopwatch_ctrl_if.sv | 28 ++
 rtl/mod_n_field.sv | 40 ++++
 rtl/stopwatch_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and encodings for the stopwatch timekeeping core.
package stopwatch_pkg;

    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned FIELD_W = 6;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } run_state_e;

    localparam logic [1:0] BLINK_NONE = 2'b00;
    localparam logic [1:0] BLINK_MIN  = 2'b01;
    localparam logic [1:0] BLINK_SEC  = 2'b10;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control inputs and display-facing outputs of the stopwatch core.
interface stopwatch_ctrl_if #(
    parameter int unsigned W = 6
);

    logic         count_tick;
    logic         adj_tick;
    logic         adj;
    logic         sel;
    logic         pause;
    logic [W-1:0] min;
    logic [W-1:0] sec;
    logic [1:0]   blink_en;
    logic         running;

    // Upstream side: tick generator, debouncers and whoever watches the outputs.
    modport master (
        output count_tick, adj_tick, adj, sel, pause,
        input  min, sec, blink_en, running
    );

    // Stopwatch core side.
    modport slave (
        input  count_tick, adj_tick, adj, sel, pause,
        output min, sec, blink_en, running
    );

endinterface

// File: rtl/mod_n_field.sv
// Wrap counter 0..MAX; advances by one on inc and flags the wrap cycle.
module mod_n_field #(
    parameter int unsigned MAX = 59,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] MaxV = W'(MAX);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         at_max;

    // Next value: only ever 0 or value+1 below MAX, so out-of-range cannot occur.
    always_comb begin
        value_d = value_q;
        at_max  = (value_q == MaxV);
        if (inc) begin
            value_d = at_max ? '0 : value_q + W'(1);
        end
    end

    // Field register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign wrap  = at_max & inc;

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch core: run/pause FSM, adjust-mode muxing and field blink control.
module stopwatch_ctrl #(
    parameter int unsigned MIN_MAX = 59,
    parameter int unsigned SEC_MAX = 59,
    parameter int unsigned W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.slave  bus
);

    import stopwatch_pkg::run_state_e;
    import stopwatch_pkg::ST_RUN;
    import stopwatch_pkg::ST_PAUSED;
    import stopwatch_pkg::BLINK_NONE;
    import stopwatch_pkg::BLINK_MIN;
    import stopwatch_pkg::BLINK_SEC;

    run_state_e   state_q;
    run_state_e   state_d;
    logic [1:0]   blink_q;
    logic [1:0]   blink_d;
    logic         sec_inc;
    logic         min_inc;
    logic         sec_wrap;
    logic [W-1:0] sec_val;
    logic [W-1:0] min_val;

    // Run/pause next state: a pause pulse toggles in every mode, adjust included.
    always_comb begin
        state_d = state_q;
        if (bus.pause) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
    end

    // Run/pause state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Field increments: adjust steps one field with no carry, otherwise seconds carry into minutes.
    always_comb begin
        sec_inc = 1'b0;
        min_inc = 1'b0;
        blink_d = BLINK_NONE;
        if (bus.adj) begin
            sec_inc = bus.adj_tick & bus.sel;
            min_inc = bus.adj_tick & ~bus.sel;
            blink_d = bus.sel ? BLINK_SEC : BLINK_MIN;
        end else begin
            sec_inc = bus.count_tick & (state_q == ST_RUN);
            min_inc = sec_wrap;
        end
    end

    // Blink enable register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q <= BLINK_NONE;
        end else begin
            blink_q <= blink_d;
        end
    end

    mod_n_field #(
        .MAX (SEC_MAX),
        .W   (W)
    ) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_inc),
        .value (sec_val),
        .wrap  (sec_wrap)
    );

    mod_n_field #(
        .MAX (MIN_MAX),
        .W   (W)
    ) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc),
        .value (min_val),
        .wrap  ()
    );

    assign bus.sec      = sec_val;
    assign bus.min      = min_val;
    assign bus.blink_en = blink_q;
    assign bus.running  = (state_q == ST_RUN);

endmodule
